// File: rtl/bf_fetch_unit_pkg.sv
// Shared opcode and state types for the Brainfuck fetch/sequencer slice.
package bf_pkg;

  typedef enum logic [2:0] {
    IN   = 3'd0,
    OUT  = 3'd1,
    BACK = 3'd2,
    IF   = 3'd3,
    MOVL = 3'd4,
    MOVR = 3'd5,
    DEC  = 3'd6,
    INC  = 3'd7
  } opcode_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    SKIP  = 2'd2,
    HALT  = 2'd3
  } fetch_state_t;

  localparam int PERF_W = 32;

  // Brackets are resolved inside the fetch unit; everything else goes downstream.
  function automatic logic is_data_op(opcode_t code);
    return (code != IF) && (code != BACK);
  endfunction

endpackage

// File: rtl/bf_fetch_unit_if.sv
// ROM port and execute-stage handshake of the fetch unit, bundled as one interface.
interface bf_fetch_unit_if #(
  parameter int ADDR_W = 10
);
  logic [ADDR_W-1:0] rom_addr;
  logic [2:0]        rom_code;
  logic              rom_overrun;
  logic              cell_zero;
  logic [2:0]        op;
  logic              op_valid;
  logic              op_ready;

  modport master (
    output rom_addr,
    output op,
    output op_valid,
    input  rom_code,
    input  rom_overrun,
    input  cell_zero,
    input  op_ready
  );

  modport slave (
    input  rom_addr,
    input  op,
    input  op_valid,
    output rom_code,
    output rom_overrun,
    output cell_zero,
    output op_ready
  );
endinterface

// File: rtl/bf_fetch_unit_loop_stack.sv
// LIFO of loop-start addresses for active `[` brackets; push and pop never coincide.
module bf_loop_stack #(
  parameter int ADDR_W = 10,
  parameter int DEPTH  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic              pop,
  input  logic [ADDR_W-1:0] din,
  output logic [ADDR_W-1:0] top,
  output logic              empty,
  output logic              full
);
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int SP_W  = $clog2(DEPTH + 1);

  logic [ADDR_W-1:0] mem [DEPTH];
  logic [SP_W-1:0]   sp;
  logic [IDX_W-1:0]  wr_idx;
  logic [IDX_W-1:0]  top_idx;

  assign wr_idx  = IDX_W'(sp);
  assign top_idx = IDX_W'(sp - SP_W'(1));
  assign empty   = (sp == '0);
  assign full    = (sp == SP_W'(DEPTH));
  assign top     = mem[top_idx];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sp <= '0;
    end else if (push && !full) begin
      sp <= sp + 1'b1;
    end else if (pop && !empty) begin
      sp <= sp - 1'b1;
    end
  end

  // Entries need no reset: they are only read below sp.
  always_ff @(posedge clk) begin
    if (push && !full) begin
      mem[wr_idx] <= din;
    end
  end

endmodule

// File: rtl/bf_fetch_unit.sv
// Brainfuck fetch/sequencer: walks the ROM, resolves brackets locally, issues data ops.
// Optional issued-op counter enabled by macro BF_FETCH_PERF_EN.
//   state | meaning
//   IDLE  | waiting for run pulse
//   FETCH | presenting data ops / resolving brackets at pc
//   SKIP  | scanning forward for the `]` matching a skipped `[`
//   HALT  | program ended or faulted; left only via rst
module bf_fetch_unit
  import bf_pkg::*;
#(
  parameter int ADDR_W      = 10,
  parameter int STACK_DEPTH = 16,
  parameter int DEPTH_W     = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                run,
  bf_fetch_unit_if.master     bus,
  output logic                halted,
  output logic                stack_err,
  output logic [PERF_W-1:0]   perf_ops
);

  fetch_state_t      state, state_n;
  logic [ADDR_W-1:0] pc, pc_n;
  logic [DEPTH_W-1:0] depth, depth_n;
  logic              err_set;
  logic              push, pop;
  logic [ADDR_W-1:0] stk_top;
  logic              stk_empty, stk_full;
  logic              op_valid_c;
  logic [2:0]        op_c;
  opcode_t           code;

  assign code = opcode_t'(bus.rom_code);

  bf_loop_stack #(
    .ADDR_W (ADDR_W),
    .DEPTH  (STACK_DEPTH)
  ) u_loop_stack (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .din   (pc),
    .top   (stk_top),
    .empty (stk_empty),
    .full  (stk_full)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      pc        <= '0;
      depth     <= '0;
      stack_err <= 1'b0;
    end else begin
      state <= state_n;
      pc    <= pc_n;
      depth <= depth_n;
      if (err_set) begin
        stack_err <= 1'b1;
      end
    end
  end

  always_comb begin
    state_n    = state;
    pc_n       = pc;
    depth_n    = depth;
    err_set    = 1'b0;
    push       = 1'b0;
    pop        = 1'b0;
    op_valid_c = 1'b0;
    op_c       = 3'd0;
    unique case (state)
      IDLE: begin
        if (run) begin
          state_n = FETCH;
          pc_n    = '0;
        end
      end
      FETCH: begin
        if (bus.rom_overrun) begin
          state_n = HALT;
        end else if (is_data_op(code)) begin
          op_valid_c = 1'b1;
          op_c       = bus.rom_code;
          if (bus.op_ready) begin
            pc_n = pc + 1'b1;
          end
        end else if (code == IF) begin
          // Brackets wait for op_ready so cell_zero reflects every prior op.
          if (bus.op_ready) begin
            if (!bus.cell_zero) begin
              if (stk_full) begin
                err_set = 1'b1;
                state_n = HALT;
              end else begin
                push = 1'b1;
                pc_n = pc + 1'b1;
              end
            end else begin
              depth_n = DEPTH_W'(1);
              pc_n    = pc + 1'b1;
              state_n = SKIP;
            end
          end
        end else begin
          if (bus.op_ready) begin
            if (stk_empty) begin
              err_set = 1'b1;
              state_n = HALT;
            end else if (!bus.cell_zero) begin
              pc_n = stk_top + 1'b1;
            end else begin
              pop  = 1'b1;
              pc_n = pc + 1'b1;
            end
          end
        end
      end
      SKIP: begin
        if (bus.rom_overrun) begin
          err_set = 1'b1;
          state_n = HALT;
        end else if (code == IF) begin
          if (depth == '1) begin
            err_set = 1'b1;
            state_n = HALT;
          end else begin
            depth_n = depth + 1'b1;
            pc_n    = pc + 1'b1;
          end
        end else if (code == BACK) begin
          depth_n = depth - 1'b1;
          pc_n    = pc + 1'b1;
          if (depth == DEPTH_W'(1)) begin
            state_n = FETCH;
          end
        end else begin
          pc_n = pc + 1'b1;
        end
      end
      HALT: begin
        state_n = HALT;
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  assign bus.rom_addr = pc;
  assign bus.op       = op_c;
  assign bus.op_valid = op_valid_c;
  assign halted       = (state == HALT);

`ifdef BF_FETCH_PERF_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_ops <= '0;
    end else if (op_valid_c && bus.op_ready && (perf_ops != '1)) begin
      perf_ops <= perf_ops + 1'b1;
    end
  end
`else
  assign perf_ops = '0;
`endif

endmodule

// File: tb/tb_bf_fetch_unit.sv
// Scoreboard bench for bf_fetch_unit: BF interpreter reference model plus ROM/execute-stage models.
module tb_bf_fetch_unit;
  import bf_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        run;
  logic        halted;
  logic        stack_err;
  logic [31:0] perf_ops;
  logic        rdy;

  bf_fetch_unit_if #(.ADDR_W(10)) bus ();

  bf_fetch_unit #(
    .ADDR_W      (10),
    .STACK_DEPTH (16),
    .DEPTH_W     (8)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .run       (run),
    .bus       (bus),
    .halted    (halted),
    .stack_err (stack_err),
    .perf_ops  (perf_ops)
  );

  always #5 clk = ~clk;

  logic [2:0]   prog [1024];
  int           plen = 0;
  byte unsigned tape [256];
  byte unsigned ptr;
  int           ex_in;

  always_comb begin
    bus.rom_overrun = (int'(bus.rom_addr) >= plen);
    bus.rom_code    = bus.rom_overrun ? 3'd0 : prog[bus.rom_addr];
  end
  assign bus.cell_zero = (tape[ptr] == 8'd0);
  assign bus.op_ready  = rdy;

  logic [2:0] exp_q [$];
  int n_pass = 0;
  int n_total = 0;

  function automatic void chk(string name, longint act, longint exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endfunction

  function automatic int in_val(int k);
    return (k * 37 + 11) % 256;
  endfunction

  // Reference interpreter: expected op stream, fault flag and final pc.
  function automatic bit model(input byte unsigned init0, output bit err, output int fpc);
    byte unsigned mt [256];
    byte unsigned mp;
    int stk [$];
    int pc, steps, k, d, j;
    err = 1'b0; fpc = 0;
    foreach (mt[i]) mt[i] = 8'd0;
    mt[0] = init0; mp = 8'd0; pc = 0; k = 0;
    exp_q.delete();
    for (steps = 0; steps < 600; steps++) begin
      if (pc >= plen) begin fpc = pc; return 1'b1; end
      case (opcode_t'(prog[pc]))
        IF: begin
          if (mt[mp] != 0) begin
            if (stk.size() == 16) begin err = 1'b1; fpc = pc; return 1'b1; end
            stk.push_back(pc);
            pc++;
          end else begin
            d = 1;
            j = pc + 1;
            while (1) begin
              if (j >= plen) begin err = 1'b1; fpc = j; return 1'b1; end
              if (prog[j] == 3'(IF)) begin
                if (d == 255) begin err = 1'b1; fpc = j; return 1'b1; end
                d++;
              end else if (prog[j] == 3'(BACK)) begin
                d--;
                if (d == 0) break;
              end
              j++;
            end
            pc = j + 1;
          end
        end
        BACK: begin
          if (stk.size() == 0) begin err = 1'b1; fpc = pc; return 1'b1; end
          if (mt[mp] != 0) pc = stk[$] + 1;
          else begin void'(stk.pop_back()); pc++; end
        end
        default: begin
          exp_q.push_back(prog[pc]);
          case (opcode_t'(prog[pc]))
            INC:  mt[mp] = mt[mp] + 8'd1;
            DEC:  mt[mp] = mt[mp] - 8'd1;
            MOVR: mp = mp + 8'd1;
            MOVL: mp = mp - 8'd1;
            IN:   begin mt[mp] = 8'(in_val(k)); k++; end
            default: ;
          endcase
          pc++;
        end
      endcase
    end
    return 1'b0;
  endfunction

  task automatic load(input string s);
    plen = s.len();
    for (int i = 0; i < plen; i++) begin
      case (s[i])
        "+": prog[i] = 3'(INC);
        "-": prog[i] = 3'(DEC);
        ">": prog[i] = 3'(MOVR);
        "<": prog[i] = 3'(MOVL);
        ".": prog[i] = 3'(OUT);
        ",": prog[i] = 3'(IN);
        "[": prog[i] = 3'(IF);
        default: prog[i] = 3'(BACK);
      endcase
    end
  endtask

  // Execute-stage model and monitor.
  int cyc = 0;
  int hs_cnt, hs_first, hs_last, stall_seen, stall_left;
  int rdy_mode = 0;
  bit prev_stall;
  logic [2:0] prev_op;
  logic [9:0] prev_addr;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        chk("stall_valid_hold", bus.op_valid, 1);
        chk("stall_op_hold", bus.op, prev_op);
        chk("stall_pc_hold", bus.rom_addr, prev_addr);
      end
      if (rdy_mode == 0) rdy = 1'b1;
      else if (rdy_mode == 1) rdy = ($urandom_range(0, 9) < 7);
      else if (bus.op_valid && stall_left > 0) begin rdy = 1'b0; stall_left--; end
      else rdy = 1'b1;
      if (bus.op_valid && rdy) begin
        chk("op_pending", exp_q.size() > 0, 1);
        if (exp_q.size() > 0) chk("op", bus.op, exp_q.pop_front());
        hs_cnt++;
        if (hs_cnt == 1) hs_first = cyc;
        hs_last = cyc;
        case (opcode_t'(bus.op))
          INC:  tape[ptr] = tape[ptr] + 8'd1;
          DEC:  tape[ptr] = tape[ptr] - 8'd1;
          MOVR: ptr = ptr + 8'd1;
          MOVL: ptr = ptr - 8'd1;
          IN:   begin tape[ptr] = 8'(in_val(ex_in)); ex_in++; end
          default: ;
        endcase
      end
      prev_stall = bus.op_valid && !rdy;
      if (prev_stall) stall_seen++;
      prev_op   = bus.op;
      prev_addr = bus.rom_addr;
    end
  end

  task automatic start(input byte unsigned init0, input int mode);
    rst = 1'b1; run = 1'b0;
    rdy_mode = mode; stall_left = 3; stall_seen = 0; hs_cnt = 0;
    foreach (tape[i]) tape[i] = 8'd0;
    tape[0] = init0; ptr = 8'd0; ex_in = 0;
    rdy = 1'b1;
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    @(negedge clk); run = 1'b1;
    @(negedge clk); run = 1'b0;
  endtask

  task automatic run_test(input string name, input string s, input byte unsigned init0,
                          input int mode, output bit ok);
    bit e;
    int fpc, n, n_ops;
    load(s);
    ok = model(init0, e, fpc);
    if (!ok) return;
    n_ops = exp_q.size();
    start(init0, mode);
    n = 0;
    while (!halted && n < 6000) begin @(negedge clk); n++; end
    chk({name, "_halted"}, halted, 1);
    repeat (3) @(negedge clk);
    chk({name, "_stack_err"}, stack_err, e);
    chk({name, "_final_pc"}, bus.rom_addr, fpc);
    chk({name, "_ops_issued"}, hs_cnt, n_ops);
    chk({name, "_ops_left"}, exp_q.size(), 0);
    chk({name, "_valid_after_halt"}, bus.op_valid, 0);
`ifdef BF_FETCH_PERF_EN
    chk({name, "_perf"}, perf_ops, hs_cnt);
`else
    chk({name, "_perf"}, perf_ops, 0);
`endif
  endtask

  initial begin
    bit ok, e;
    int fpc, done, tries, len, open, r;
    string s, c, ds, deep;
    rst = 1'b1; run = 1'b0; rdy = 1'b1;
    #1;
    chk("reset_op_valid", bus.op_valid, 0);
    chk("reset_op", bus.op, 0);
    chk("reset_halted", halted, 0);
    chk("reset_stack_err", stack_err, 0);
    chk("reset_rom_addr", bus.rom_addr, 0);
    chk("reset_perf", perf_ops, 0);

    run_test("straight", "+++.", 8'd0, 0, ok);
    chk("straight_consecutive", hs_last - hs_first, 3);
    run_test("skip_loop", "[+]", 8'd0, 0, ok);
    run_test("loop_twice", "+[-]", 8'd1, 0, ok);
    run_test("nested_skip", "[[+]+]", 8'd0, 0, ok);
    run_test("stall", "+.", 8'd0, 2, ok);
    chk("stall_cycles", stall_seen, 3);
    run_test("lone_back", "]", 8'd0, 0, ok);
    s = "+";
    for (int i = 0; i < 17; i++) s = {s, "["};
    run_test("stack_overflow", s, 8'd0, 0, ok);
    run_test("unclosed_skip", "[+", 8'd0, 0, ok);
    deep = "";
    for (int i = 0; i < 260; i++) deep = {deep, "["};
    run_test("depth_saturate", deep, 8'd0, 0, ok);

    // Reset in the middle of an endless loop.
    load("+[]");
    void'(model(8'd0, e, fpc));
    start(8'd0, 0);
    repeat (20) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("midrst_op_valid", bus.op_valid, 0);
    chk("midrst_halted", halted, 0);
    chk("midrst_stack_err", stack_err, 0);
    chk("midrst_rom_addr", bus.rom_addr, 0);
    chk("midrst_perf", perf_ops, 0);
    chk("midrst_ops_left", exp_q.size(), 0);
    run_test("after_rst_back", "]", 8'd0, 0, ok);

    ds = "+-><.,";
    c = " ";
    done = 0;
    tries = 0;
    while (done < 30 && tries < 300) begin
      tries++;
      s = "";
      open = 0;
      len = $urandom_range(3, 24);
      for (int i = 0; i < len; i++) begin
        r = $urandom_range(0, 99);
        if (r < 12 && open < 4) begin s = {s, "["}; open++; end
        else if (r < 22 && open > 0) begin s = {s, "]"}; open--; end
        else begin c[0] = ds[$urandom_range(0, 5)]; s = {s, c}; end
      end
      r = $urandom_range(0, 99);
      if (r >= 5) while (open > 0) begin s = {s, "]"}; open--; end
      if (r < 3) s = {s, "]"};
      run_test("random", s, 8'($urandom_range(0, 3)), 1, ok);
      if (ok) done++;
    end
    chk("random_programs_run", done, 30);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
